bcd_2_bin_seq: RTL and testbench

- Sequential BCD-to-binary converter, the inverse of the existing binary-to-BCD block.
- Takes a packed NUM_DIGITS-digit BCD word, least-significant digit in bits [3:0].
- Produces the unsigned binary value using a digit-serial multiply-by-10-and-add loop, one digit per clock, most-significant digit first.
- Used to turn keypad/display-style BCD operands into binary before they enter the sequential multiplier datapath.

---
 rtl/bcd_2_bin_seq.sv | 141 ++++++++++++++
 tb/tb_bcd_2_bin_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_2_bin_seq.sv
// bcd_2_bin_seq: digit-serial BCD-to-binary converter, MSD first, acc*10+digit per clock.
// Optional macro BCD_2_BIN_CHECK_EN enables the invalid-digit (>9) Error flag.
module bcd_2_bin_seq #(
    parameter int NUM_DIGITS = 4,
    parameter int OUT_W      = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Start,
    input  logic [4*NUM_DIGITS-1:0] Data_Input,
    output logic [OUT_W-1:0]        Data_Output,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Error
);

    localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [OUT_W-1:0]        acc;
    logic [OUT_W-1:0]        acc_n;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_n;
    logic [4*NUM_DIGITS-1:0] opnd;
    logic [4*NUM_DIGITS-1:0] opnd_n;
    logic [OUT_W-1:0]        dout_n;
    logic                    busy_n;
    logic                    done_n;
    logic [3:0]              digit;
    logic [OUT_W-1:0]        mac;
    logic                    accept;

    assign accept = (state == IDLE) && Start;

    // Pick the latched digit addressed by the down-counter
    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cnt == CNT_W'(i)) begin
                digit = opnd[4*i +: 4];
            end
        end
    end

    // acc*10 + digit as two shifts and adds, wrapping at OUT_W bits
    always_comb begin
        mac = (acc << 3) + (acc << 1) + OUT_W'(digit);
    end

    // Next-state and datapath update
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        opnd_n  = opnd;
        dout_n  = Data_Output;
        busy_n  = Busy;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    opnd_n  = Data_Input;
                    acc_n   = '0;
                    cnt_n   = CNT_TOP;
                    busy_n  = 1'b1;
                    state_n = CONVERT;
                end
            end
            CONVERT: begin
                acc_n = mac;
                if (cnt == '0) begin
                    dout_n  = mac;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            opnd        <= '0;
            Data_Output <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            state       <= state_n;
            acc         <= acc_n;
            cnt         <= cnt_n;
            opnd        <= opnd_n;
            Data_Output <= dout_n;
            Busy        <= busy_n;
            Done        <= done_n;
        end
    end

`ifdef BCD_2_BIN_CHECK_EN
    logic bad;

    // Flag any nibble above 9 in the operand being accepted
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (Data_Input[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
    end

    // Error follows the most recently accepted operand
    always_ff @(posedge clk) begin
        if (rst) begin
            Error <= 1'b0;
        end else if (accept) begin
            Error <= bad;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign Error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_2_bin_seq.sv
// tb_bcd_2_bin_seq: directed plus randomized checks of bcd_2_bin_seq
// against a transaction-level model built from plain decimal arithmetic.
module tb_bcd_2_bin_seq;

    localparam int ND = 4;
    localparam int OW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   din = 16'h0;
    logic [OW-1:0] dout;
    logic          busy;
    logic          done;
    logic          err;

    int errors = 0;
    int checks = 0;

    bit m_busy = 0;
    bit m_done = 0;
    bit m_err  = 0;
    int m_rem  = 0;
    int m_val  = 0;
    int m_out  = 0;
    bit chk_on = 0;

    bcd_2_bin_seq #(.NUM_DIGITS(ND), .OUT_W(OW)) dut (
        .clk(clk),
        .rst(rst),
        .Start(start),
        .Data_Input(din),
        .Data_Output(dout),
        .Busy(busy),
        .Done(done),
        .Error(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Decimal value of the nibbles (raw, even if >9), wrapped to OW bits
    function automatic int ref_val(input logic [15:0] d);
        int v;
        int w;
        v = 0;
        w = 1;
        for (int i = 0; i < ND; i++) begin
            v = v + int'(d[4*i +: 4]) * w;
            w = w * 10;
        end
        return v % (1 << OW);
    endfunction

    function automatic bit ref_bad(input logic [15:0] d);
        bit b;
        b = 0;
`ifdef BCD_2_BIN_CHECK_EN
        for (int i = 0; i < ND; i++) begin
            if (d[4*i +: 4] > 4'd9) b = 1;
        end
`endif
        return b;
    endfunction

    // Transaction model: accept in idle, result appears ND edges later
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0;
            m_done = 0;
            m_err  = 0;
            m_rem  = 0;
            m_val  = 0;
            m_out  = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1;
                    m_rem  = ND;
                    m_val  = ref_val(din);
                    m_err  = ref_bad(din);
                end
            end else begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_out  = m_val;
                    m_done = 1;
                    m_busy = 0;
                end
            end
        end
    end

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("busy", int'(busy), int'(m_busy));
            check("done", int'(done), int'(m_done));
            check("dout", int'(dout), m_out);
            check("error", int'(err), int'(m_err));
        end
    end

    task automatic conv(input logic [15:0] d, input bit hold,
                        input logic [15:0] d2, output int lat);
        start = 1'b1;
        din   = d;
        @(posedge clk);
        @(negedge clk);
        if (hold) din = d2;
        else start = 1'b0;
        lat = 0;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (hold) start = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        chk_on = 1;
        check("reset_dout", int'(dout), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);

        conv(16'h0000, 0, 16'h0, lat);
        check("lat_0000", lat, 4);
        check("val_0000", int'(dout), 0);

        conv(16'h1024, 0, 16'h0, lat);
        check("lat_1024", lat, 4);
        check("val_1024", int'(dout), 1024);
        conv(16'h9999, 0, 16'h0, lat);
        check("lat_9999", lat, 4);
        check("val_9999", int'(dout), 9999);

        conv(16'h0028, 1, 16'h0999, lat);
        check("lat_0028", lat, 4);
        check("val_0028", int'(dout), 28);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) n++;
        end
        check("extra_done", n, 0);

        start = 1'b1;
        din   = 16'h1000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_done", int'(done), 0);
        check("abort_dout", int'(dout), 0);
        check("abort_busy", int'(busy), 0);
        conv(16'h0001, 0, 16'h0, lat);
        check("val_0001", int'(dout), 1);

        conv(16'h00A0, 0, 16'h0, lat);
        check("val_00a0", int'(dout), 100);
`ifdef BCD_2_BIN_CHECK_EN
        check("err_00a0", int'(err), 1);
`else
        check("err_00a0", int'(err), 0);
`endif
        conv(16'h0005, 0, 16'h0, lat);
        check("val_0005", int'(dout), 5);
        check("err_0005", int'(err), 0);

        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) begin
                din = 16'($urandom);
            end else begin
                for (int i = 0; i < ND; i++) begin
                    din[4*i +: 4] = 4'($urandom_range(0, 9));
                end
            end
            rst = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
